tank_mover: RTL and testbench

//  Tile-grid tank movement controller, one instance per player. Decodes a per-player

---
 rtl/tank_pkg.sv | 40 ++++
 rtl/tank_mover.sv | 148 ++++++++++++++
 tb/tb_tank_mover.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types and helpers for the tile-grid tank mover
package tank_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_MOVE   = 2'd3
  } state_t;

  localparam logic [1:0] TILE_EMPTY = 2'd0;

  function automatic int tile_index(input int row, input int col, input int map_w);
    return row * map_w + col;
  endfunction

  function automatic logic signed [1:0] dir_dx(input dir_t d);
    case (d)
      DIR_RIGHT: return 2'sb01;
      DIR_LEFT:  return 2'sb11;
      default:   return 2'sb00;
    endcase
  endfunction

  function automatic logic signed [1:0] dir_dy(input dir_t d);
    case (d)
      DIR_DOWN: return 2'sb01;
      DIR_UP:   return 2'sb11;
      default:  return 2'sb00;
    endcase
  endfunction

endpackage

// File: rtl/tank_mover.sv
// rtl/tank_mover.sv - per-player tank movement controller on a tile grid
module tank_mover
  import tank_pkg::*;
#(
  parameter int          TILE_SHIFT = 5,
  parameter int          MAP_W      = 20,
  parameter int          MAP_H      = 15,
  parameter int          STEP       = 4,
  parameter int          START_COL  = 1,
  parameter int          START_ROW  = 13,
  parameter logic [7:0]  KEY_UP     = 8'h1A,
  parameter logic [7:0]  KEY_DOWN   = 8'h16,
  parameter logic [7:0]  KEY_LEFT   = 8'h04,
  parameter logic [7:0]  KEY_RIGHT  = 8'h07,
  parameter int          AW         = $clog2(MAP_W * MAP_H)
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic [7:0]    keycode,
  output logic          map_rd_en,
  output logic [AW-1:0] map_rd_addr,
  input  logic [1:0]    map_rd_data,
  output logic [9:0]    tank_x,
  output logic [9:0]    tank_y,
  output logic [1:0]    facing,
  output logic          moving
);

  localparam logic signed [10:0] MAP_W_S = 11'(MAP_W);
  localparam logic signed [10:0] MAP_H_S = 11'(MAP_H);
  localparam logic [9:0]         STEP_V  = 10'(STEP);
  localparam logic [9:0]         X0      = 10'(START_COL << TILE_SHIFT);
  localparam logic [9:0]         Y0      = 10'(START_ROW << TILE_SHIFT);

  state_t                r_state, w_state_next;
  dir_t                  r_facing, w_dir;
  logic [9:0]            r_col, r_row, r_tcol, r_trow;
  logic [9:0]            r_x, r_y, r_tx, r_ty;
  logic                  r_rd_en;
  logic [AW-1:0]         r_rd_addr;
  logic                  w_key_hit, w_in_range, w_arrive;
  logic signed [1:0]     w_dx2, w_dy2;
  logic signed [10:0]    w_tcol, w_trow;
  logic [AW-1:0]         w_addr;
  logic [9:0]            w_nx, w_ny;

  // Key decode and signed target tile so that -1 and MAP_W/MAP_H are both caught
  always_comb begin
    w_key_hit = 1'b1;
    w_dir     = DIR_UP;
    case (keycode)
      KEY_UP:    w_dir = DIR_UP;
      KEY_RIGHT: w_dir = DIR_RIGHT;
      KEY_DOWN:  w_dir = DIR_DOWN;
      KEY_LEFT:  w_dir = DIR_LEFT;
      default:   w_key_hit = 1'b0;
    endcase
    w_dx2      = dir_dx(w_dir);
    w_dy2      = dir_dy(w_dir);
    w_tcol     = $signed({1'b0, r_col}) + $signed({{9{w_dx2[1]}}, w_dx2});
    w_trow     = $signed({1'b0, r_row}) + $signed({{9{w_dy2[1]}}, w_dy2});
    w_in_range = !w_tcol[10] && (w_tcol < MAP_W_S) && !w_trow[10] && (w_trow < MAP_H_S);
    w_addr     = AW'(tile_index(int'(w_trow), int'(w_tcol), MAP_W));
  end

  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    case (r_facing)
      DIR_RIGHT: w_nx = r_x + STEP_V;
      DIR_LEFT:  w_nx = r_x - STEP_V;
      DIR_DOWN:  w_ny = r_y + STEP_V;
      default:   w_ny = r_y - STEP_V;
    endcase
    w_arrive = (w_nx == r_tx) && (w_ny == r_ty);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_key_hit && w_in_range) w_state_next = ST_LOOKUP;
      ST_LOOKUP: w_state_next = ST_CHECK;
      ST_CHECK:  w_state_next = (map_rd_data == TILE_EMPTY) ? ST_MOVE : ST_IDLE;
      default:   if (w_arrive) w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    moving      = (r_state == ST_MOVE);
    map_rd_en   = r_rd_en;
    map_rd_addr = r_rd_addr;
    tank_x      = r_x;
    tank_y      = r_y;
    facing      = r_facing;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_facing  <= DIR_UP;
      r_col     <= 10'(START_COL);
      r_row     <= 10'(START_ROW);
      r_tcol    <= 10'(START_COL);
      r_trow    <= 10'(START_ROW);
      r_x       <= X0;
      r_y       <= Y0;
      r_tx      <= X0;
      r_ty      <= Y0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_key_hit) begin
            r_facing <= w_dir;
            if (w_in_range) begin
              r_rd_en   <= 1'b1;
              r_rd_addr <= w_addr;
              r_tcol    <= w_tcol[9:0];
              r_trow    <= w_trow[9:0];
            end
          end
        end
        ST_CHECK: begin
          if (map_rd_data == TILE_EMPTY) begin
            r_tx <= 10'(r_tcol << TILE_SHIFT);
            r_ty <= 10'(r_trow << TILE_SHIFT);
          end
        end
        ST_MOVE: begin
          r_x <= w_nx;
          r_y <= w_ny;
          if (w_arrive) begin
            r_col <= r_tcol;
            r_row <= r_trow;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tank_mover.sv
// tb/tb_tank_mover.sv - self-checking bench for tank_mover
module tb_tank_mover;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] k1, k0, k2;
  logic       rd_en1, rd_en0, rd_en2;
  logic [8:0] rd_addr1, rd_addr0, rd_addr2;
  logic [1:0] rd_data1, rd_data0, rd_data2;
  logic [9:0] x1, y1, x0, y0, x2, y2;
  logic [1:0] f1, f0, f2;
  logic       mv1, mv0, mv2;
  logic [1:0] map [0:299];

  int checks = 0;
  int errors = 0;

  always #5 frame_clk = ~frame_clk;

  tank_mover u1 (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(k1),
    .map_rd_en(rd_en1), .map_rd_addr(rd_addr1), .map_rd_data(rd_data1),
    .tank_x(x1), .tank_y(y1), .facing(f1), .moving(mv1));

  tank_mover #(.START_COL(0)) u0 (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(k0),
    .map_rd_en(rd_en0), .map_rd_addr(rd_addr0), .map_rd_data(rd_data0),
    .tank_x(x0), .tank_y(y0), .facing(f0), .moving(mv0));

  tank_mover #(.START_COL(18), .START_ROW(1), .KEY_UP(8'h52), .KEY_DOWN(8'h51),
               .KEY_LEFT(8'h50), .KEY_RIGHT(8'h4F)) u2 (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(k2),
    .map_rd_en(rd_en2), .map_rd_addr(rd_addr2), .map_rd_data(rd_data2),
    .tank_x(x2), .tank_y(y2), .facing(f2), .moving(mv2));

  // One-cycle-latency map RAM per instance
  always @(posedge frame_clk) begin
    if (rd_en1) rd_data1 <= map[rd_addr1];
    if (rd_en0) rd_data0 <= map[rd_addr0];
    if (rd_en2) rd_data2 <= map[rd_addr2];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_map();
    for (int i = 0; i < 300; i++) map[i] = 2'd0;
  endtask

  task automatic do_reset();
    k1 = 8'h00; k0 = 8'h00; k2 = 8'h00;
    Reset = 1'b1;
    repeat (2) @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  typedef struct {
    logic [7:0] key;
    int         blk;
    int         e_face;
    int         e_x;
    int         e_y;
    int         e_moved;
  } vec_t;
  vec_t vt [8];

  // Reference model: tile position plus a glide phase counter
  int m_col, m_row, m_phase, m_k, m_tc, m_tr, m_face, m_addr, m_dx, m_dy;

  function automatic int key_dir(input logic [7:0] kc);
    case (kc)
      8'h1A:   return 0;
      8'h07:   return 1;
      8'h16:   return 2;
      8'h04:   return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_step(input logic [7:0] kc);
    int d, dx, dy, tc, tr;
    case (m_phase)
      0: begin
        d = key_dir(kc);
        if (d >= 0) begin
          m_face = d;
          dx = (d == 1) ? 1 : (d == 3) ? -1 : 0;
          dy = (d == 2) ? 1 : (d == 0) ? -1 : 0;
          tc = m_col + dx;
          tr = m_row + dy;
          if (tc >= 0 && tc < 20 && tr >= 0 && tr < 15) begin
            m_tc = tc; m_tr = tr; m_dx = dx; m_dy = dy;
            m_addr = tr * 20 + tc;
            m_phase = 1;
          end
        end
      end
      1: m_phase = 2;
      2: begin
        m_phase = (map[m_addr] == 2'd0) ? 3 : 0;
        m_k = 0;
      end
      default: begin
        m_k++;
        if (m_k == 8) begin
          m_col = m_tc; m_row = m_tr; m_phase = 0; m_k = 0;
        end
      end
    endcase
  endtask

  initial begin
    int  seen_rd, seen_mv, found, r;
    logic [7:0] kr;

    vt[0] = '{8'h07, -1,  1, 64, 416, 1};
    vt[1] = '{8'h04, -1,  3,  0, 416, 1};
    vt[2] = '{8'h1A, -1,  0, 32, 384, 1};
    vt[3] = '{8'h16, -1,  2, 32, 448, 1};
    vt[4] = '{8'h1A, 241, 0, 32, 416, 0};
    vt[5] = '{8'h07, 262, 1, 32, 416, 0};
    vt[6] = '{8'h4F, -1,  0, 32, 416, 0};
    vt[7] = '{8'h00, -1,  0, 32, 416, 0};

    clear_map();
    do_reset();
    check("reset_x", x1, 32);
    check("reset_y", y1, 416);
    check("reset_facing", f1, 0);
    check("reset_moving", mv1, 0);
    check("reset_rd_en", rd_en1, 0);
    check("reset_rd_addr", rd_addr1, 0);
    check("reset_p2_x", x2, 576);
    check("reset_p2_y", y2, 32);
    check("reset_c0_x", x0, 0);

    // Right from (1,13): read at 262, eight 4-pixel steps
    k1 = 8'h07;
    @(negedge frame_clk);
    check("t1_rd_en", rd_en1, 1);
    check("t1_rd_addr", rd_addr1, 262);
    k1 = 8'h00;
    @(negedge frame_clk);
    check("t1_rd_en_pulse", rd_en1, 0);
    @(negedge frame_clk);
    check("t1_moving_start", mv1, 1);
    check("t1_x_hold", x1, 32);
    for (int i = 1; i <= 8; i++) begin
      @(negedge frame_clk);
      check("t1_x_step", x1, 32 + 4 * i);
      check("t1_y_hold", y1, 416);
      check("t1_moving", mv1, (i < 8) ? 1 : 0);
    end

    foreach (vt[i]) begin
      clear_map();
      do_reset();
      if (vt[i].blk >= 0) map[vt[i].blk] = 2'd1;
      k1 = vt[i].key;
      @(negedge frame_clk);
      k1 = 8'h00;
      seen_mv = 0;
      repeat (14) begin
        @(negedge frame_clk);
        if (mv1) seen_mv = 1;
      end
      check("tbl_facing", f1, vt[i].e_face);
      check("tbl_x", x1, vt[i].e_x);
      check("tbl_y", y1, vt[i].e_y);
      check("tbl_moved", seen_mv, vt[i].e_moved);
    end

    // Release the key mid-glide: glide still completes
    clear_map();
    do_reset();
    k1 = 8'h07;
    repeat (6) @(negedge frame_clk);
    k1 = 8'h00;
    repeat (12) @(negedge frame_clk);
    check("t4_x", x1, 64);
    check("t4_moving", mv1, 0);

    // Left edge: no read, no motion, facing still updates
    do_reset();
    k0 = 8'h04;
    seen_rd = 0; seen_mv = 0;
    repeat (8) begin
      @(negedge frame_clk);
      if (rd_en0) seen_rd = 1;
      if (mv0) seen_mv = 1;
    end
    check("t3_facing", f0, 3);
    check("t3_rd_seen", seen_rd, 0);
    check("t3_mv_seen", seen_mv, 0);
    check("t3_x", x0, 0);
    k0 = 8'h00;

    // Asynchronous reset in the middle of a glide
    do_reset();
    k1 = 8'h07;
    @(negedge frame_clk);
    k1 = 8'h00;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge frame_clk);
      if (x1 == 10'd48) found = 1;
    end
    check("t5_reach48", found, 1);
    #2 Reset = 1'b1;
    #1;
    check("t5_x", x1, 32);
    check("t5_y", y1, 416);
    check("t5_moving", mv1, 0);
    check("t5_rd_en", rd_en1, 0);
    @(negedge frame_clk);
    Reset = 1'b0;

    // Player-2 key on player-1 instance, then player-2 instance moving left
    do_reset();
    k1 = 8'h4F;
    seen_rd = 0; seen_mv = 0;
    repeat (12) begin
      @(negedge frame_clk);
      if (rd_en1) seen_rd = 1;
      if (mv1) seen_mv = 1;
    end
    check("t6_p1_rd", seen_rd, 0);
    check("t6_p1_mv", seen_mv, 0);
    check("t6_p1_x", x1, 32);
    k1 = 8'h00;
    k2 = 8'h50;
    @(negedge frame_clk);
    check("t6_p2_rd_en", rd_en2, 1);
    check("t6_p2_addr", rd_addr2, 37);
    k2 = 8'h00;
    repeat (12) @(negedge frame_clk);
    check("t6_p2_x", x2, 544);
    check("t6_p2_y", y2, 32);
    check("t6_p2_facing", f2, 3);

    // Randomized run against the reference model
    for (int i = 0; i < 300; i++) map[i] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
    do_reset();
    m_col = 1; m_row = 13; m_phase = 0; m_k = 0; m_face = 0; m_addr = 0;
    m_tc = 1; m_tr = 13; m_dx = 0; m_dy = 0;
    for (int c = 0; c < 700; c++) begin
      r = $urandom_range(0, 7);
      case (r)
        0: kr = 8'h1A;
        1: kr = 8'h16;
        2: kr = 8'h04;
        3: kr = 8'h07;
        6: kr = 8'($urandom_range(0, 255));
        7: kr = 8'h4F;
        default: kr = 8'h00;
      endcase
      k1 = kr;
      @(posedge frame_clk);
      model_step(kr);
      @(negedge frame_clk);
      check("rnd_x", x1, 32'(m_col * 32 + ((m_phase == 3) ? m_dx * 4 * m_k : 0)));
      check("rnd_y", y1, 32'(m_row * 32 + ((m_phase == 3) ? m_dy * 4 * m_k : 0)));
      check("rnd_facing", f1, 32'(m_face));
      check("rnd_moving", mv1, (m_phase == 3) ? 1 : 0);
      check("rnd_rd_en", rd_en1, (m_phase == 1) ? 1 : 0);
      check("rnd_rd_addr", rd_addr1, 32'(m_addr));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
